// File: rtl/ehl_ahb_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : ehl_ahb_decoder
//  Description : AHB-Lite address decoder and response multiplexer for one
//                master and NSLV slaves plus a default slave. Decodes haddr
//                into one-hot selects, tracks the data-phase owner and
//                returns that owner's hready/hresp/hrdata. Counts non-IDLE
//                transfers that fall through to the default slave.
//  Revision    : 1.0 - initial release
// ============================================================================
module ehl_ahb_decoder #(
    parameter int                 NSLV     = 4,
    parameter logic [32*NSLV-1:0] SLV_BASE = {NSLV{32'h0000_0000}},
    parameter logic [32*NSLV-1:0] SLV_MASK = {NSLV{32'hF000_0000}}
) (
    input  logic                 hclk,
    input  logic                 hresetn,
    input  logic [31:0]          haddr,
    input  logic [1:0]           htrans,
    output logic [NSLV-1:0]      hsel_slv,
    output logic                 hsel_def,
    input  logic [NSLV-1:0]      s_hready,
    input  logic [2*NSLV-1:0]    s_hresp,
    input  logic [32*NSLV-1:0]   s_hrdata,
    input  logic                 d_hready,
    input  logic [1:0]           d_hresp,
    input  logic [31:0]          d_hrdata,
    output logic                 hready_out,
    output logic [1:0]           hresp,
    output logic [31:0]          hrdata,
    output logic [7:0]           miss_cnt,
    input  logic                 miss_clr
);

    // Index width stays at least one bit so a single-slave build still works.
    localparam int IDXW = (NSLV > 1) ? $clog2(NSLV) : 1;
    localparam logic [7:0] c_MISS_MAX = 8'hFF;

    // Data-phase owner: nobody, a real slave (index held separately), or the
    // default slave.
    typedef enum logic [1:0] {
        DSEL_NONE = 2'd0,
        DSEL_SLV  = 2'd1,
        DSEL_DEF  = 2'd2
    } dsel_e;

    dsel_e             r_dsel;
    logic [IDXW-1:0]   r_dsel_idx;
    dsel_e             w_dsel_nxt;
    logic [IDXW-1:0]   w_dsel_idx_nxt;

    logic              w_hit;
    logic [IDXW-1:0]   w_hit_idx;
    logic              w_miss_inc;
    logic [7:0]        r_miss_cnt;

    // Address decode: scan upward and latch the first match so the lowest
    // index wins and hsel_slv can never carry more than one bit.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = '0;
        hsel_slv  = '0;
        for (int i = 0; i < NSLV; i++) begin
            if (!w_hit &&
                ((haddr & SLV_MASK[32*i +: 32]) ==
                 (SLV_BASE[32*i +: 32] & SLV_MASK[32*i +: 32]))) begin
                w_hit       = 1'b1;
                w_hit_idx   = IDXW'(i);
                hsel_slv[i] = 1'b1;
            end
        end
    end

    assign hsel_def = ~w_hit;

    // Owner register: reset drops straight to NONE so the master sees an
    // immediate zero-wait OKAY even if reset lands mid-transfer.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_dsel     <= DSEL_NONE;
            r_dsel_idx <= '0;
        end else begin
            r_dsel     <= w_dsel_nxt;
            r_dsel_idx <= w_dsel_idx_nxt;
        end
    end

    // Next owner: only advances on a completing cycle; NONSEQ/SEQ take the
    // decoded target, IDLE/BUSY leave nobody owning the next data phase.
    always_comb begin
        w_dsel_nxt     = r_dsel;
        w_dsel_idx_nxt = r_dsel_idx;
        if (hready_out) begin
            if (htrans[1]) begin
                if (w_hit) begin
                    w_dsel_nxt     = DSEL_SLV;
                    w_dsel_idx_nxt = w_hit_idx;
                end else begin
                    w_dsel_nxt     = DSEL_DEF;
                    w_dsel_idx_nxt = '0;
                end
            end else begin
                w_dsel_nxt     = DSEL_NONE;
                w_dsel_idx_nxt = '0;
            end
        end
    end

    // Response mux: compare-and-select per slave so unselected slave inputs
    // (even X) never reach the master.
    always_comb begin
        hready_out = 1'b1;
        hresp      = 2'b00;
        hrdata     = 32'h0;
        case (r_dsel)
            DSEL_SLV: begin
                for (int i = 0; i < NSLV; i++) begin
                    if (r_dsel_idx == IDXW'(i)) begin
                        hready_out = s_hready[i];
                        hresp      = s_hresp[2*i +: 2];
                        hrdata     = s_hrdata[32*i +: 32];
                    end
                end
            end
            DSEL_DEF: begin
                hready_out = d_hready;
                hresp      = d_hresp;
                hrdata     = d_hrdata;
            end
            default: begin
                hready_out = 1'b1;
                hresp      = 2'b00;
                hrdata     = 32'h0;
            end
        endcase
    end

    assign w_miss_inc = hready_out & htrans[1] & ~w_hit;

    // Saturating miss counter; clear wins over a coincident increment.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_miss_cnt <= 8'h00;
        end else if (miss_clr) begin
            r_miss_cnt <= 8'h00;
        end else if (w_miss_inc && (r_miss_cnt != c_MISS_MAX)) begin
            r_miss_cnt <= r_miss_cnt + 8'h01;
        end
    end

    assign miss_cnt = r_miss_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ehl_ahb_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ehl_ahb_decoder
//  Description : Directed scoreboard bench for ehl_ahb_decoder. The stimulus
//                pushes the expected completion of each data phase; a monitor
//                on the falling edge pops and compares when a phase completes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ehl_ahb_decoder;

    localparam int NSLV = 4;
    localparam logic [32*NSLV-1:0] c_BASE = {32'h3000_0000, 32'h2000_0000,
                                             32'h1000_0000, 32'h2000_0000};
    localparam logic [32*NSLV-1:0] c_MASK = {32'hF000_0000, 32'hFF00_0000,
                                             32'hF000_0000, 32'hF000_0000};
    localparam logic [31:0] c_DDATA = 32'h0D0D_0D0D;

    logic                 hclk = 1'b0;
    logic                 hresetn;
    logic [31:0]          haddr;
    logic [1:0]           htrans;
    logic [NSLV-1:0]      hsel_slv;
    logic                 hsel_def;
    logic [NSLV-1:0]      s_hready;
    logic [2*NSLV-1:0]    s_hresp;
    logic [32*NSLV-1:0]   s_hrdata;
    logic                 d_hready;
    logic [1:0]           d_hresp;
    logic [31:0]          d_hrdata;
    logic                 hready_out;
    logic [1:0]           hresp;
    logic [31:0]          hrdata;
    logic [7:0]           miss_cnt;
    logic                 miss_clr;

    ehl_ahb_decoder #(
        .NSLV     (NSLV),
        .SLV_BASE (c_BASE),
        .SLV_MASK (c_MASK)
    ) dut (
        .hclk       (hclk),
        .hresetn    (hresetn),
        .haddr      (haddr),
        .htrans     (htrans),
        .hsel_slv   (hsel_slv),
        .hsel_def   (hsel_def),
        .s_hready   (s_hready),
        .s_hresp    (s_hresp),
        .s_hrdata   (s_hrdata),
        .d_hready   (d_hready),
        .d_hresp    (d_hresp),
        .d_hrdata   (d_hrdata),
        .hready_out (hready_out),
        .hresp      (hresp),
        .hrdata     (hrdata),
        .miss_cnt   (miss_cnt),
        .miss_clr   (miss_clr)
    );

    always #5 hclk = ~hclk;

    typedef struct {
        logic [1:0]  resp;
        logic [31:0] data;
        int          waits;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_err    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic push(input logic [1:0] resp, input logic [31:0] data, input int waits);
        exp_t e;
        e.resp  = resp;
        e.data  = data;
        e.waits = waits;
        sb.push_back(e);
    endtask

    task automatic cyc();
        @(posedge hclk);
        #1;
    endtask

    task automatic set_slv(input int i, input logic rdy, input logic [1:0] resp, input logic [31:0] data);
        s_hready[i]         = rdy;
        s_hresp[2*i +: 2]   = resp;
        s_hrdata[32*i +: 32] = data;
    endtask

    task automatic slv_defaults();
        for (int i = 0; i < NSLV; i++) set_slv(i, 1'b1, 2'b00, 32'h5A00_0000 | i);
        d_hready = 1'b1;
        d_hresp  = 2'b00;
        d_hrdata = c_DDATA;
    endtask

    // Monitor: tracks whether a data phase is open from the master's view and
    // checks each completion against the head of the scoreboard.
    int   mon_waits = 0;
    logic mon_in_dp = 1'b0;
    always @(negedge hclk) begin
        if (!hresetn) begin
            mon_in_dp = 1'b0;
            mon_waits = 0;
        end else begin
            if (mon_in_dp) begin
                if (!hready_out) begin
                    mon_waits++;
                end else if (sb.size() == 0) begin
                    chk("sb_unexpected_completion", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("dp_hresp", {30'd0, hresp}, {30'd0, e.resp});
                    chk("dp_hrdata", hrdata, e.data);
                    chk("dp_waits", mon_waits, e.waits);
                end
            end
            if (hready_out) begin
                mon_in_dp = htrans[1];
                mon_waits = 0;
            end
        end
    end

    initial begin
        // 1 Reset with random slave inputs and an active transfer request
        hresetn  = 1'b0;
        miss_clr = 1'b0;
        haddr    = 32'h1000_0004;
        htrans   = 2'b10;
        s_hready = NSLV'($urandom);
        s_hresp  = (2*NSLV)'($urandom);
        for (int i = 0; i < NSLV; i++) s_hrdata[32*i +: 32] = $urandom;
        d_hready = 1'b0;
        d_hresp  = 2'b01;
        d_hrdata = $urandom;
        cyc();
        cyc();
        chk("rst_hready", {31'd0, hready_out}, 32'd1);
        chk("rst_hresp", {30'd0, hresp}, 32'd0);
        chk("rst_hrdata", hrdata, 32'd0);
        chk("rst_miss_cnt", {24'd0, miss_cnt}, 32'd0);
        chk("rst_sel_follows", {28'd0, hsel_slv}, 32'h2);
        htrans = 2'b00;
        slv_defaults();
        cyc();
        hresetn = 1'b1;
        cyc();

        // 2 Hit on slave1 with two wait states
        haddr  = 32'h1000_0004;
        htrans = 2'b10;
        chk("hit_hsel_slv", {28'd0, hsel_slv}, 32'h2);
        chk("hit_hsel_def", {31'd0, hsel_def}, 32'd0);
        push(2'b00, 32'h0000_CAFE, 2);
        cyc();
        htrans = 2'b00;
        set_slv(1, 1'b0, 2'b00, 32'h0);
        #1 chk("hit_wait1", {31'd0, hready_out}, 32'd0);
        cyc();
        chk("hit_wait2", {31'd0, hready_out}, 32'd0);
        cyc();
        set_slv(1, 1'b1, 2'b00, 32'h0000_CAFE);
        #1 chk("hit_done_rdata", hrdata, 32'h0000_CAFE);
        cyc();
        slv_defaults();

        // 3 Miss to default slave with two-cycle ERROR
        haddr  = 32'hF000_0000;
        htrans = 2'b10;
        #1 chk("miss_hsel_def", {31'd0, hsel_def}, 32'd1);
        chk("miss_hsel_slv", {28'd0, hsel_slv}, 32'd0);
        push(2'b01, 32'h1234_5678, 1);
        cyc();
        chk("miss_cnt_1", {24'd0, miss_cnt}, 32'd1);
        htrans   = 2'b00;
        d_hready = 1'b0;
        d_hresp  = 2'b01;
        d_hrdata = 32'h1234_5678;
        #1 chk("err_c1_hready", {31'd0, hready_out}, 32'd0);
        chk("err_c1_hresp", {30'd0, hresp}, 32'd1);
        cyc();
        d_hready = 1'b1;
        cyc();
        slv_defaults();
        chk("miss_cnt_idle_hold", {24'd0, miss_cnt}, 32'd1);

        // 4 Overlapping windows: lowest index wins
        haddr = 32'h2000_0000;
        #1 chk("overlap_sel", {28'd0, hsel_slv}, 32'h1);
        haddr = 32'h3000_0040;
        #1 chk("slv3_sel", {28'd0, hsel_slv}, 32'h8);
        cyc();

        // 5 Pipeline: slave0 (one wait) then slave3 back-to-back
        haddr  = 32'h2000_0010;
        htrans = 2'b10;
        push(2'b00, 32'h0000_AAAA, 1);
        cyc();
        haddr  = 32'h3000_0020;
        htrans = 2'b11;
        push(2'b00, 32'h0000_BBBB, 0);
        set_slv(0, 1'b0, 2'b00, 32'h0);
        set_slv(3, 1'b1, 2'b00, 32'h0000_BBBB);
        #1 chk("pipe_wait", {31'd0, hready_out}, 32'd0);
        chk("pipe_addr_held_sel", {28'd0, hsel_slv}, 32'h8);
        cyc();
        set_slv(0, 1'b1, 2'b00, 32'h0000_AAAA);
        #1 chk("pipe_first_rdata", hrdata, 32'h0000_AAAA);
        cyc();
        htrans = 2'b00;
        set_slv(0, 1'b0, 2'b10, 32'hFFFF_FFFF);
        #1 chk("pipe_switched_rdata", hrdata, 32'h0000_BBBB);
        chk("pipe_switched_hready", {31'd0, hready_out}, 32'd1);
        cyc();
        slv_defaults();
        cyc();

        // 6 Counter saturation, clear priority, IDLE to unmapped address
        for (int k = 0; k < 300; k++) begin
            haddr  = 32'hF000_0000 + 32'(4 * k);
            htrans = 2'b10;
            push(2'b00, c_DDATA, 0);
            cyc();
        end
        chk("cnt_saturated", {24'd0, miss_cnt}, 32'hFF);
        push(2'b00, c_DDATA, 0);
        cyc();
        chk("cnt_stays_ff", {24'd0, miss_cnt}, 32'hFF);
        miss_clr = 1'b1;
        push(2'b00, c_DDATA, 0);
        cyc();
        miss_clr = 1'b0;
        chk("cnt_clr_priority", {24'd0, miss_cnt}, 32'd0);
        htrans = 2'b00;
        haddr  = 32'hF000_0100;
        cyc();
        chk("cnt_idle_no_inc", {24'd0, miss_cnt}, 32'd0);
        chk("idle_zero_wait", {31'd0, hready_out}, 32'd1);
        chk("idle_okay", {30'd0, hresp}, 32'd0);
        chk("idle_rdata", hrdata, 32'd0);
        cyc();

        // Reset asserted in the middle of a waited data phase
        haddr  = 32'h1000_0000;
        htrans = 2'b10;
        cyc();
        htrans = 2'b00;
        set_slv(1, 1'b0, 2'b00, 32'h0);
        #1 chk("midrst_pre_wait", {31'd0, hready_out}, 32'd0);
        hresetn = 1'b0;
        #1 chk("midrst_hready", {31'd0, hready_out}, 32'd1);
        chk("midrst_hresp", {30'd0, hresp}, 32'd0);
        cyc();
        hresetn = 1'b1;
        slv_defaults();
        cyc();
        cyc();

        chk("sb_drained", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
